// File: rtl/bsg_manycore_sdr_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bsg_manycore_sdr_reset_sequencer
// Description : Bring-up controller for one row of manycore-link-to-SDR tiles.
//               It releases the token, uplink, downlink and downstream resets in
//               that order. Each phase is held for H cycles, so the row's
//               daisy-chained reset path can settle before the next release.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_manycore_sdr_reset_sequencer #(
  parameter int hold_width_p  = 8,
  parameter int num_tiles_x_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [hold_width_p-1:0] hold_cycles_i,
  output logic                    async_token_reset_o,
  output logic                    async_uplink_reset_o,
  output logic                    async_downlink_reset_o,
  output logic                    async_downstream_reset_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    TOK_REL = 3'd2,
    UP_REL  = 3'd3,
    DN_REL  = 3'd4,
    DS_REL  = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [hold_width_p-1:0] c_one = {{(hold_width_p-1){1'b0}}, 1'b1};

  // The integration floor (hold >= tiles on the row) must be programmable
  // through the hold input. If it is not, no legal hold value exists.
  if (num_tiles_x_p > (2**hold_width_p) - 1) begin : g_floor_check
    $error("num_tiles_x_p cannot be represented in hold_cycles_i");
  end

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [hold_width_p-1:0] r_cnt;
  logic [hold_width_p-1:0] w_cnt_nxt;
  logic [hold_width_p-1:0] r_hold;
  logic [hold_width_p-1:0] w_hold_nxt;
  logic [hold_width_p-1:0] w_start_hold;

  // A hold value of zero is promoted to one cycle per phase.
  assign w_start_hold = (hold_cycles_i == '0) ? c_one : hold_cycles_i;

  // Next-state logic. An accepted start overrides every other transition.
  // Each phase lasts r_hold cycles, counted down from r_hold-1 to 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    if (start_i) begin
      w_state_nxt = ASSERT;
      w_hold_nxt  = w_start_hold;
      w_cnt_nxt   = w_start_hold - c_one;
    end else begin
      case (r_state)
        ASSERT, TOK_REL, UP_REL, DN_REL, DS_REL: begin
          if (r_cnt == '0) begin
            w_cnt_nxt = r_hold - c_one;
            case (r_state)
              ASSERT:  w_state_nxt = TOK_REL;
              TOK_REL: w_state_nxt = UP_REL;
              UP_REL:  w_state_nxt = DN_REL;
              DN_REL:  w_state_nxt = DS_REL;
              default: w_state_nxt = DONE;
            endcase
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
        IDLE, DONE: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, counter, latched hold and registered Moore outputs.
  // The outputs are decoded from the next state, so they change on the same
  // edge as the state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state                  <= IDLE;
      r_cnt                    <= '0;
      r_hold                   <= c_one;
      async_token_reset_o      <= 1'b1;
      async_uplink_reset_o     <= 1'b1;
      async_downlink_reset_o   <= 1'b1;
      async_downstream_reset_o <= 1'b1;
      busy_o                   <= 1'b0;
      done_o                   <= 1'b0;
      state_o                  <= IDLE;
    end else begin
      r_state                  <= w_state_nxt;
      r_cnt                    <= w_cnt_nxt;
      r_hold                   <= w_hold_nxt;
      async_token_reset_o      <= (w_state_nxt == IDLE) || (w_state_nxt == ASSERT);
      async_uplink_reset_o     <= (w_state_nxt == IDLE) || (w_state_nxt == ASSERT) ||
                                  (w_state_nxt == TOK_REL);
      async_downlink_reset_o   <= (w_state_nxt == IDLE) || (w_state_nxt == ASSERT) ||
                                  (w_state_nxt == TOK_REL) || (w_state_nxt == UP_REL);
      async_downstream_reset_o <= (w_state_nxt == IDLE) || (w_state_nxt == ASSERT) ||
                                  (w_state_nxt == TOK_REL) || (w_state_nxt == UP_REL) ||
                                  (w_state_nxt == DN_REL);
      busy_o                   <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      done_o                   <= (w_state_nxt == DONE);
      state_o                  <= w_state_nxt;
    end
  end

endmodule
`default_nettype wire
